// File: rtl/burst_pkg.sv
// Shared types, default sizing and helpers for the burst address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_pkg;

    localparam int DEF_ADDR_WIDTH    = 10;
    localparam int DEF_STRIDE_LEN    = 4;
    localparam int DEF_MAX_BURST_LEN = 16;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        BURST = 2'b10
    } state_e;

    // True for 1, 2, 4, 8 ...; zero is not a power of two.
    function automatic logic is_pow2(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/burst_addr_gen_if.sv
// Request and beat-address handshake bundle between controller, generator and SRAM port.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the address stream.
interface burst_addr_gen_if #(
    parameter int ADDR_WIDTH    = burst_pkg::DEF_ADDR_WIDTH,
    parameter int STRIDE_LEN    = burst_pkg::DEF_STRIDE_LEN,
    parameter int MAX_BURST_LEN = burst_pkg::DEF_MAX_BURST_LEN
);
    localparam int LEN_WIDTH = $clog2(MAX_BURST_LEN) + 1;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [STRIDE_LEN-1:0] req_stride;
    logic [1:0]            req_mode;
    logic                  addr_valid;
    logic                  addr_ready;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  addr_last;
    logic                  busy;
    logic                  err;

    // Generator side.
    modport slave (
        input  req_valid, req_addr, req_len, req_stride, req_mode, addr_ready,
        output req_ready, addr_valid, addr_out, addr_last, busy, err
    );

    // Controller / downstream side.
    modport master (
        output req_valid, req_addr, req_len, req_stride, req_mode, addr_ready,
        input  req_ready, addr_valid, addr_out, addr_last, busy, err
    );

endinterface

// File: rtl/burst_addr_next.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Latency: zero cycles (pure logic).
// Backpressure: none; the caller decides when to take the result.
module burst_addr_next
    import burst_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int STRIDE_LEN    = DEF_STRIDE_LEN,
    parameter int MAX_BURST_LEN = DEF_MAX_BURST_LEN
) (
    input  burst_mode_e                       mode,
    input  logic [ADDR_WIDTH-1:0]             cur,
    input  logic [STRIDE_LEN-1:0]             stride,
    input  logic [$clog2(MAX_BURST_LEN):0]    len,
    output logic [ADDR_WIDTH-1:0]             next
);
    localparam int LEN_WIDTH = $clog2(MAX_BURST_LEN) + 1;
    // Window product must hold both len*stride and the 2^ADDR_WIDTH limit.
    localparam int PW = ((ADDR_WIDTH + 1) > (LEN_WIDTH + STRIDE_LEN)) ?
                        (ADDR_WIDTH + 1) : (LEN_WIDTH + STRIDE_LEN);
    localparam logic [PW-1:0] SPACE = PW'(1) << ADDR_WIDTH;

    logic [PW-1:0]         w_len_x;
    logic [PW-1:0]         w_stride_x;
    logic [PW-1:0]         w_win;
    logic [ADDR_WIDTH-1:0] w_sum;
    logic [ADDR_WIDTH-1:0] w_mask;

    assign w_len_x    = PW'(len);
    assign w_stride_x = PW'(stride);
    assign w_win      = w_len_x * w_stride_x;
    assign w_sum      = cur + ADDR_WIDTH'(stride);
    assign w_mask     = ADDR_WIDTH'(w_win - PW'(1));

    // Select the per-mode update; a window larger than the address space degrades to INCR.
    always_comb begin
        next = cur;
        case (mode)
            FIXED: next = cur;
            INCR:  next = w_sum;
            WRAP: begin
                if (w_win > SPACE) begin
                    next = w_sum;
                end else begin
                    next = (cur & ~w_mask) | (w_sum & w_mask);
                end
            end
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/burst_addr_gen.sv
// Burst address generator: one request in, one address per beat out (FIXED/INCR/WRAP).
// Latency: first beat valid 2 cycles after the request handshake; one idle cycle between bursts.
// Backpressure: beat outputs hold while addr_ready=0; req_ready only high in IDLE.
// Optional stats counters enabled by defining BURST_ADDR_GEN_STATS_EN.
module burst_addr_gen
    import burst_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int STRIDE_LEN    = DEF_STRIDE_LEN,
    parameter int MAX_BURST_LEN = DEF_MAX_BURST_LEN
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef BURST_ADDR_GEN_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_bursts,
    output logic [15:0] stat_errors,
`endif
    burst_addr_gen_if.slave bus
);
    localparam int LEN_WIDTH = $clog2(MAX_BURST_LEN) + 1;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_start;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [STRIDE_LEN-1:0] r_stride;
    burst_mode_e           r_mode;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_beat;
    logic                  w_err;
    logic                  w_illegal;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_next;

    // A latched request is rejected on bad length, reserved mode, or a non-power-of-two wrap window.
    assign w_illegal = (r_len == '0) ||
                       (r_len > LEN_WIDTH'(MAX_BURST_LEN)) ||
                       (r_mode == RSVD) ||
                       ((r_mode == WRAP) &&
                        (!is_pow2(32'(r_len)) || !is_pow2(32'(r_stride))));

    assign w_last = (r_state == BURST) && (r_cnt == '0);

    burst_addr_next #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STRIDE_LEN   (STRIDE_LEN),
        .MAX_BURST_LEN(MAX_BURST_LEN)
    ) u_next (
        .mode  (r_mode),
        .cur   (r_addr),
        .stride(r_stride),
        .len   (r_len),
        .next  (w_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_load         = 1'b0;
        w_beat         = 1'b0;
        w_err          = 1'b0;
        bus.req_ready  = 1'b0;
        bus.addr_valid = 1'b0;
        bus.busy       = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                bus.busy = 1'b1;
                if (w_illegal) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                bus.busy       = 1'b1;
                bus.addr_valid = 1'b1;
                if (bus.addr_ready) begin
                    w_beat = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, beat address and remaining-beat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start  <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_stride <= '0;
            r_mode   <= FIXED;
        end else begin
            if (w_accept) begin
                r_start  <= bus.req_addr;
                r_len    <= bus.req_len;
                r_stride <= bus.req_stride;
                r_mode   <= burst_mode_e'(bus.req_mode);
            end
            if (w_load) begin
                r_addr <= r_start;
                r_cnt  <= r_len - LEN_WIDTH'(1);
            end else if (w_beat) begin
                r_addr <= w_next;
                r_cnt  <= r_cnt - LEN_WIDTH'(1);
            end
        end
    end

    assign bus.addr_out  = r_addr;
    assign bus.addr_last = w_last;
    assign bus.err       = w_err;

`ifdef BURST_ADDR_GEN_STATS_EN
    logic [15:0] r_stat_bursts;
    logic [15:0] r_stat_errors;

    // Saturating completion and error counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_bursts <= '0;
            r_stat_errors <= '0;
        end else if (stat_clr) begin
            r_stat_bursts <= '0;
            r_stat_errors <= '0;
        end else begin
            if (w_beat && w_last && (r_stat_bursts != 16'hFFFF)) begin
                r_stat_bursts <= r_stat_bursts + 16'd1;
            end
            if (w_err && (r_stat_errors != 16'hFFFF)) begin
                r_stat_errors <= r_stat_errors + 16'd1;
            end
        end
    end

    assign stat_bursts = r_stat_bursts;
    assign stat_errors = r_stat_errors;
`endif

endmodule

// File: doc/burst_addr_gen.md
Name: burst_addr_gen

Overview:
- Parametrised successor to the single-mode burst address modifier.
- Accepts one burst request per valid/ready handshake and emits one address per beat on a valid/ready output stream.
- Supports FIXED, INCR and WRAP modes, with per-request length and stride.
- Sits between the burst-transaction controller and the SRAM address port in the bt_top datapath.

Parameters:
- ADDR_WIDTH, 10, address bus width; address arithmetic is modulo 2^ADDR_WIDTH.
- STRIDE_LEN, 4, stride field width.
- MAX_BURST_LEN, 16, largest legal beat count; must be a power of two, at least 2.
- LEN_WIDTH, $clog2(MAX_BURST_LEN)+1, derived, not overridable; width of the length field.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- req_valid  in  1  burst request valid
- req_ready  out  1  request accepted when valid&&ready
- req_addr  in  ADDR_WIDTH  start address
- req_len  in  LEN_WIDTH  beat count, legal range 1..MAX_BURST_LEN
- req_stride  in  STRIDE_LEN  per-beat increment
- req_mode  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- addr_valid  out  1  addr_out valid
- addr_ready  in  1  downstream accepts beat
- addr_out  out  ADDR_WIDTH  current beat address
- addr_last  out  1  final beat of burst
- busy  out  1  burst in progress
- err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset values: state IDLE; req_ready=1, addr_valid=0, addr_out=0, addr_last=0, busy=0, err=0.
- Reset mid-burst aborts the burst immediately. No beat is issued after rstn deasserts until a new request arrives.
- States are IDLE, CHECK and BURST.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch all req_* fields and go to CHECK.
- CHECK (one cycle; req_ready=0, busy=1). The request is illegal if any of the following hold:
  - req_len==0
  - req_len>MAX_BURST_LEN
  - req_mode==11
  - WRAP mode and req_len is not a power of two
  - WRAP mode and req_stride is not a power of two
- CHECK outcomes:
  - Illegal: err=1 for exactly this cycle, no beats issued, return to IDLE.
  - Legal: load addr_out=start address and beat counter=len-1, go to BURST.
- BURST:
  - addr_valid=1, busy=1.
  - addr_out, addr_last and addr_valid stay stable while addr_ready=0.
  - addr_last=1 only when beat counter==0.
  - Each addr_valid&&addr_ready handshake decrements the counter and updates addr_out per the mode rules below.
  - The handshake on the last beat goes to IDLE: addr_valid=0 and req_ready=1 the following cycle.
- Mode update rules:
  - FIXED: addr_out is unchanged every beat.
  - INCR: addr_out += stride, modulo 2^ADDR_WIDTH. Wrap past the top of the address space is legal and silent. stride=0 behaves as FIXED.
  - WRAP: window W=len*stride, computed at ADDR_WIDTH+1 bits. next=(cur & ~(W-1)) | ((cur+stride) & (W-1)). The burst returns to the aligned window base after crossing the window top. If W exceeds 2^ADDR_WIDTH, treat as INCR.
- Latency: req handshake at cycle N, first addr_valid at N+2. One idle bubble between bursts.
- len=1 gives a single beat with addr_last=1 on the first beat.
- req_* inputs are ignored outside IDLE. A request held valid during BURST is accepted only once the block is back in IDLE.

Optional Feature:
- Macro: BURST_ADDR_GEN_STATS_EN.
- With the macro defined, the block adds three ports: stat_clr (in, 1), stat_bursts (out, 16) and stat_errors (out, 16).
  - stat_bursts increments on every legal burst's final beat.
  - stat_errors increments on every err pulse.
  - Both counters saturate at 16'hFFFF, reset to 0, and clear synchronously on stat_clr.
  - If stat_clr and an increment occur in the same cycle, the clear wins.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- The shared package burst_pkg holds:
  - typedef enum logic [1:0] burst_mode_e {FIXED, INCR, WRAP, RSVD}
  - typedef enum state_e {IDLE, CHECK, BURST}
  - the default ADDR_WIDTH, STRIDE_LEN and MAX_BURST_LEN constants
  - an is_pow2 function
- Sub-module burst_addr_next: purely combinational next-address computation (mode, cur, stride, len -> next). It is instantiated once and unit-testable in isolation.

Test Plan:
- INCR: addr=0x3F8, len=4, stride=4, addr_ready=1 -> beats 0x3F8, 0x3FC, 0x000, 0x004; addr_last on the 4th beat; first addr_valid 2 cycles after the request handshake.
- WRAP: addr=0x034, len=4, stride=4 (W=16) -> beats 0x034, 0x038, 0x03C, 0x030.
- FIXED: addr=0x100, len=3, with addr_ready toggled 1,0,0,1,1 -> three beats of 0x100; outputs held stable while addr_ready=0.
- Illegal requests: len=0, then mode=11, then WRAP with len=3 -> each gives one err pulse, zero beats, and req_ready back high 2 cycles after the handshake. With stats enabled, stat_errors=3.
- Assert rstn low mid-burst (beat 2 of 8) -> all outputs at reset values; the next request, len=2 INCR stride=1 from 0x010, gives 0x010, 0x011.
- Back-to-back: req_valid held high for two INCR len=2 requests -> second accepted only after the first burst's last beat; one-cycle gap observed.
